// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin arbitrated two-cycle writes into a small register bank
module reg_bank_arbiter #(
    parameter int NREQ = 4,
    parameter int NREG = 4,
    parameter int AW   = 2,
    parameter int DW   = 8,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   wr_addr,
    input  logic [NREQ*DW-1:0]   wr_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic [IW-1:0]        last_id,
    input  logic [AW-1:0]        rd_addr,
    output logic [DW-1:0]        rd_data
);
    typedef enum logic {IDLE, WRITE} state_t;
    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     last_id_q, last_id_d;
    logic [IW-1:0]     win_q, win_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [DW-1:0]     bank_q [NREG];
    logic [DW-1:0]     bank_d [NREG];
    logic              found;
    logic [IW-1:0]     win, cand;
    // first requester at or after ptr, wrapping around
    always_comb begin
        found = 1'b0;
        win = '0;
        cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win = cand;
            end
        end
    end
    // next state: capture a winner in IDLE, commit (or discard on clear) in WRITE
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        last_id_d = last_id_q;
        win_d = win_q;
        addr_d = addr_q;
        data_d = data_q;
        gnt_d = '0;
        bank_d = bank_q;
        if (state_q == IDLE) begin
            if (clear) begin
                for (int r = 0; r < NREG; r++) bank_d[r] = '0;
            end else if (found) begin
                addr_d = wr_addr[int'(win)*AW +: AW];
                data_d = wr_data[int'(win)*DW +: DW];
                gnt_d = NREQ'(1) << win;
                last_id_d = win;
                win_d = win;
                state_d = WRITE;
            end
        end else begin
            for (int r = 0; r < NREG; r++)
                bank_d[r] = clear ? '0 : (int'(addr_q) == r) ? data_q : bank_q[r];
            ptr_d = IW'((int'(win_q) + 1) % NREQ);
            state_d = IDLE;
        end
    end
    // state registers, cleared asynchronously
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q <= '0;
            last_id_q <= '0;
            win_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            gnt_q <= '0;
            for (int r = 0; r < NREG; r++) bank_q[r] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            last_id_q <= last_id_d;
            win_q <= win_d;
            addr_q <= addr_d;
            data_q <= data_d;
            gnt_q <= gnt_d;
            bank_q <= bank_d;
        end
    end
    // asynchronous read port; unmapped addresses read as zero
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NREG; r++)
            if (int'(rd_addr) == r) rd_data = bank_q[r];
    end
    assign gnt = gnt_q;
    assign busy = (state_q == WRITE);
    assign last_id = last_id_q;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed scenarios with a grant scoreboard for reg_bank_arbiter
module tb_reg_bank_arbiter;
    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  req = '0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [1:0]  rd_addr = '0;
    logic [3:0]  gnt;
    logic        busy;
    logic [1:0]  last_id;
    logic [7:0]  rd_data;
    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int mon_id;

    reg_bank_arbiter #(.NREQ(4), .NREG(4), .AW(2), .DW(8)) dut (
        .CLK(CLK), .reset(reset), .clear(clear), .req(req),
        .wr_addr(wr_addr), .wr_data(wr_data), .gnt(gnt), .busy(busy),
        .last_id(last_id), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_w(input int i, input int a, input int d);
        wr_addr[i*2 +: 2] = 2'(a);
        wr_data[i*8 +: 8] = 8'(d);
    endtask

    task automatic rd_chk(input string tag, input int a, input int e);
        rd_addr = 2'(a);
        #1;
        chk(tag, rd_data, e);
    endtask

    // scoreboard: every grant pulse must match the next expected winner
    always @(negedge CLK) begin
        if (reset) begin
            chk("busy_vs_gnt", busy, gnt != 0);
            if (gnt != 0) begin
                if (exp_q.size() == 0) chk("unexpected_gnt", gnt, 0);
                else begin
                    mon_id = exp_q.pop_front();
                    chk("sb_gnt", gnt, 1 << mon_id);
                    chk("sb_last_id", last_id, mon_id);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_last_id", last_id, 0);
        for (int a = 0; a < 4; a++) rd_chk("rst_bank", a, 0);
        tick();
        reset = 1'b1;
        // single writer
        set_w(0, 2, 8'hA5);
        req = 4'b0001;
        rd_addr = 2'd2;
        exp_q.push_back(0);
        tick();
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_busy", busy, 1);
        chk("t1_last_id", last_id, 0);
        chk("t1_rd_early", rd_data, 0);
        req = '0;
        tick();
        chk("t1_gnt_off", gnt, 0);
        chk("t1_busy_off", busy, 0);
        chk("t1_rd", rd_data, 8'hA5);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        // fairness with all requesters held
        for (int i = 0; i < 4; i++) set_w(i, i, 8'h10 + i);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) exp_q.push_back(k % 4);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t2_gnt", gnt, (k % 2 == 0) ? (1 << ((k / 2) % 4)) : 0);
            if (k == 8) req = '0;
        end
        for (int a = 0; a < 4; a++) rd_chk("t2_bank", a, 8'h10 + a);
        // rotation: serve 1, then 1001 picks 3 before 0
        set_w(1, 0, 8'h55);
        req = 4'b0010;
        exp_q.push_back(1);
        tick();
        chk("t3_pre_gnt", gnt, 4'b0010);
        req = '0;
        tick();
        set_w(0, 1, 8'h66);
        set_w(3, 2, 8'h77);
        req = 4'b1001;
        exp_q.push_back(3);
        exp_q.push_back(0);
        tick();
        chk("t3_first", gnt, 4'b1000);
        req = 4'b0001;
        tick();
        tick();
        chk("t3_second", gnt, 4'b0001);
        req = '0;
        tick();
        rd_chk("t3_bank0", 0, 8'h55);
        rd_chk("t3_bank1", 1, 8'h66);
        rd_chk("t3_bank2", 2, 8'h77);
        rd_chk("t3_bank3", 3, 8'h13);
        // clear during WRITE; 1011 from ptr=1 must pick requester 1
        set_w(1, 0, 8'h3C);
        set_w(0, 3, 8'hEE);
        set_w(3, 1, 8'hDD);
        req = 4'b1011;
        exp_q.push_back(1);
        tick();
        chk("t4_gnt", gnt, 4'b0010);
        clear = 1'b1;
        req = '0;
        tick();
        clear = 1'b0;
        chk("t4_gnt_off", gnt, 0);
        chk("t4_last_id", last_id, 1);
        for (int a = 0; a < 4; a++) rd_chk("t4_bank", a, 0);
        // ptr=2: 0110 picks 2, then requester 1 granted and reset hits mid-WRITE
        set_w(1, 1, 8'hBB);
        set_w(2, 2, 8'h99);
        req = 4'b0110;
        exp_q.push_back(2);
        tick();
        chk("t5_pre_gnt", gnt, 4'b0100);
        req = 4'b0010;
        tick();
        rd_chk("t5_pre_bank", 2, 8'h99);
        tick();
        chk("t5_gnt_before_rst", gnt, 4'b0010);
        chk("t5_busy_before_rst", busy, 1);
        reset = 1'b0;
        req = '0;
        #1;
        chk("t5_rst_gnt", gnt, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_last_id", last_id, 0);
        for (int a = 0; a < 4; a++) rd_chk("t5_rst_bank", a, 0);
        reset = 1'b1;
        set_w(0, 1, 8'h44);
        set_w(3, 0, 8'hCC);
        req = 4'b1001;
        exp_q.push_back(0);
        tick();
        chk("t5_gnt", gnt, 4'b0001);
        req = '0;
        tick();
        rd_chk("t5_bank1", 1, 8'h44);
        rd_chk("t5_bank0", 0, 0);
        // same-address conflict from ptr=0
        set_w(3, 0, 8'h77);
        req = 4'b1000;
        exp_q.push_back(3);
        tick();
        req = '0;
        tick();
        set_w(0, 3, 8'h11);
        set_w(1, 3, 8'h22);
        req = 4'b0011;
        exp_q.push_back(0);
        exp_q.push_back(1);
        tick();
        chk("t6_gnt0", gnt, 4'b0001);
        req = 4'b0010;
        tick();
        rd_chk("t6_mid", 3, 8'h11);
        tick();
        chk("t6_gnt1", gnt, 4'b0010);
        req = '0;
        tick();
        rd_chk("t6_bank3", 3, 8'h22);
        rd_chk("t6_bank0", 0, 8'h77);
        rd_chk("t6_bank1", 1, 8'h44);
        rd_chk("t6_bank2", 2, 0);
        // clear in IDLE suppresses arbitration
        req = 4'b0001;
        clear = 1'b1;
        tick();
        chk("t7_gnt", gnt, 0);
        chk("t7_busy", busy, 0);
        clear = 1'b0;
        req = '0;
        for (int a = 0; a < 4; a++) rd_chk("t7_bank", a, 0);
        tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
